// File: rtl/codec_pkg.sv
// Shared definitions for the codec frame controller: state encoding,
// default timing parameters and the timer preload helper.
package codec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FEED  = 3'd1,
    ST_GAP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned LINE_GAP_DEF  = 2;
  localparam int unsigned DRAIN_CYC_DEF = 16;
  localparam int unsigned CNT_W         = 16;

  // The cycle after a load is the first timed cycle, so a window of N cycles
  // ends when the counter reads zero, i.e. it starts at N-1.
  function automatic logic [CNT_W-1:0] cnt_preload(input int unsigned cycles);
    return (cycles == 0) ? '0 : CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/ctrl_down_cnt.sv
// Loadable down-counter with a zero flag; shared by the line-gap and
// drain timing of the frame controller.
module ctrl_down_cnt
  import codec_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_d, cnt_q;

  // clr wins over load, load wins over dec; the counter saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/codec_frame_ctrl.sv
// Frame controller: feeds a W x H pixel frame into the codec with line gaps,
// then waits for the codec output to go quiet before signalling completion.
module codec_frame_ctrl
  import codec_pkg::*;
#(
  parameter int unsigned LINE_GAP  = LINE_GAP_DEF,
  parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [9:0]  cfg_width,
  input  logic [9:0]  cfg_height,
  input  logic        src_valid,
  input  logic [7:0]  src_data,
  output logic        src_ready,
  output logic        codec_en,
  output logic [7:0]  codec_data,
  input  logic        codec_en_out,
  input  logic        out_afull,
  output logic        busy,
  output logic        frame_done,
  output logic        err_cfg,
  output logic [19:0] pix_cnt,
  output logic [2:0]  dbg_state
);

  localparam logic [CNT_W-1:0] GAP_LOAD   = cnt_preload(LINE_GAP);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = cnt_preload(DRAIN_CYC);

  state_e      state_q, state_d;
  logic [9:0]  width_q, width_d, height_q, height_d;
  logic [9:0]  col_q, col_d, row_q, row_d;
  logic [19:0] pix_cnt_q, pix_cnt_d;
  logic        codec_en_q, codec_en_d;
  logic [7:0]  codec_data_q, codec_data_d;
  logic        err_cfg_q, err_cfg_d;

  logic             tmr_clr, tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_load_val;
  logic             xfer, cfg_ok, row_end, last_row;

  // Source handshake: a pixel moves when src_valid && src_ready in the same
  // cycle; src_ready depends only on state and out_afull, never on src_valid.
  // An abort in the same cycle discards the pixel.
  assign src_ready = (state_q == ST_FEED) && !out_afull;
  assign xfer      = src_valid && src_ready && !abort;
  assign cfg_ok    = (cfg_width >= 10'd2) && (cfg_height >= 10'd1);
  assign row_end   = (col_q == width_q - 10'd1);
  assign last_row  = (row_q == height_q - 10'd1);

  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    col_d        = col_q;
    row_d        = row_q;
    pix_cnt_d    = pix_cnt_q;
    codec_en_d   = xfer;
    codec_data_d = xfer ? src_data : codec_data_q;
    err_cfg_d    = 1'b0;
    tmr_clr      = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = GAP_LOAD;
    tmr_dec      = 1'b0;

    if (xfer) begin
      pix_cnt_d = pix_cnt_q + 20'd1;
    end

    if (abort) begin
      state_d = ST_IDLE;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              width_d   = cfg_width;
              height_d  = cfg_height;
              col_d     = '0;
              row_d     = '0;
              pix_cnt_d = '0;
              state_d   = ST_FEED;
            end else begin
              err_cfg_d = 1'b1;
            end
          end
        end
        ST_FEED: begin
          if (xfer) begin
            if (row_end) begin
              col_d = '0;
              row_d = row_q + 10'd1;
              if (last_row) begin
                state_d      = ST_DRAIN;
                tmr_load     = 1'b1;
                tmr_load_val = DRAIN_LOAD;
              end else if (LINE_GAP > 0) begin
                state_d      = ST_GAP;
                tmr_load     = 1'b1;
                tmr_load_val = GAP_LOAD;
              end
            end else begin
              col_d = col_q + 10'd1;
            end
          end
        end
        ST_GAP: begin
          if (tmr_zero) begin
            state_d = ST_FEED;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        ST_DRAIN: begin
          // Any codec output activity restarts the quiet window.
          if (codec_en_out) begin
            tmr_load     = 1'b1;
            tmr_load_val = DRAIN_LOAD;
          end else if (tmr_zero) begin
            state_d = ST_DONE;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      pix_cnt_q    <= '0;
      codec_en_q   <= 1'b0;
      codec_data_q <= '0;
      err_cfg_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pix_cnt_q    <= pix_cnt_d;
      codec_en_q   <= codec_en_d;
      codec_data_q <= codec_data_d;
      err_cfg_q    <= err_cfg_d;
    end
  end

  ctrl_down_cnt #(.W(CNT_W)) u_tmr (
    .clk      (clk),
    .reset    (reset),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  assign codec_en   = codec_en_q;
  assign codec_data = codec_data_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);
  assign err_cfg    = err_cfg_q;
  assign pix_cnt    = pix_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/codec_frame_ctrl.md
CODEC_FRAME_CTRL -- requirements
Module: codec_frame_ctrl

Interface
REQ-001 Parameter LINE_GAP, default 2: idle cycles inserted after each completed row except the last, so the context line buffers can settle.
REQ-002 Parameter DRAIN_CYC, default 16: quiet cycles (no codec en_out) required after the last pixel before the frame is declared complete.
REQ-003 Port clk  input  1  single clock; all logic rises on posedge clk.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  single-cycle frame start request.
REQ-006 Port abort  input  1  synchronous abort of the current frame.
REQ-007 Port cfg_width  input  10  pixels per row, sampled on accepted start.
REQ-008 Port cfg_height  input  10  rows per frame, sampled on accepted start.
REQ-009 Port src_valid  input  1  source pixel valid.
REQ-010 Port src_data  input  8  source pixel.
REQ-011 Port src_ready  output  1  controller accepts a pixel this cycle.
REQ-012 Port codec_en  output  1  pixel strobe to the codec en input.
REQ-013 Port codec_data  output  8  pixel to the codec data_in input.
REQ-014 Port codec_en_out  input  1  codec output-valid, used for drain tracking.
REQ-015 Port out_afull  input  1  downstream bitstream buffer almost full.
REQ-016 Port busy  output  1  high in every state except IDLE.
REQ-017 Port frame_done  output  1  one-cycle pulse on frame completion.
REQ-018 Port err_cfg  output  1  one-cycle pulse when start is rejected.
REQ-019 Port pix_cnt  output  20  count of pixels accepted in the current or last frame.

Function
REQ-020 The FSM SHALL have states IDLE, FEED, GAP, DRAIN and DONE.
REQ-021 In IDLE, start with cfg_width>=2 and 1<=cfg_height SHALL take the following actions:
- latch the configuration;
- clear col, row and pix_cnt;
- enter FEED.
REQ-022 In IDLE, start with an invalid configuration SHALL pulse err_cfg for 1 cycle, and the FSM SHALL stay in IDLE.
REQ-023 start outside IDLE SHALL be ignored, with no err_cfg.
REQ-024 src_ready SHALL equal (state==FEED) && !out_afull, combinationally; a transfer is src_valid && src_ready.
REQ-025 On each transfer, on the next edge:
- codec_en SHALL be 1;
- codec_data SHALL equal the transferred src_data;
- pix_cnt SHALL increment.
codec_en SHALL be 0 in every cycle that follows a non-transfer cycle, which gives fixed latency 1.
REQ-026 A transfer at col==W-1 SHALL take the following actions:
- set col to 0 and increment row;
- if row==H-1, go to DRAIN;
- else if LINE_GAP>0, go to GAP;
- else stay in FEED.
Any other transfer SHALL increment col.
REQ-027 GAP SHALL hold src_ready at 0 for exactly LINE_GAP cycles and then return to FEED.
REQ-028 DRAIN SHALL load a down-counter with DRAIN_CYC on entry and reload it on every codec_en_out=1; it SHALL decrement otherwise and go to DONE when it reads 0 with codec_en_out=0.
REQ-029 DONE SHALL last 1 cycle, assert frame_done in that cycle and go to IDLE; pix_cnt SHALL hold until the next accepted start.
REQ-030 When out_afull rises in the same cycle as src_valid, no transfer SHALL occur in that cycle.
REQ-031 abort=1 in any state SHALL send the FSM to IDLE at the next edge.
- codec_en SHALL be 0 from that edge onward.
- No frame_done SHALL be issued.
- abort SHALL take priority over start in the same cycle.
REQ-032 Counters SHALL be unsigned: col and row 10 bits, pix_cnt 20 bits (max 1023x1023 fits); overflow is not reachable.

Reset
REQ-033 On reset low, all of the following SHALL hold immediately:
- state=IDLE;
- codec_en=0, codec_data=0;
- src_ready=0, busy=0, frame_done=0, err_cfg=0;
- pix_cnt=0, col=0, row=0, drain counter=0.
REQ-034 Reset asserted mid-frame SHALL discard the frame with no frame_done pulse; operation SHALL resume only on a new start after reset is released.

Structure
REQ-035 The state encoding (IDLE=0, FEED=1, GAP=2, DRAIN=3, DONE=4) and the default LINE_GAP and DRAIN_CYC values SHALL live in the shared package codec_pkg.
REQ-036 A single sub-module, ctrl_down_cnt, SHALL be a loadable down-counter with a zero flag, reused for the GAP and DRAIN timing.

Verification
REQ-037 The bench SHALL cover the following directed scenarios:
- W=4, H=2, LINE_GAP=2, src_valid held high -> 8 codec_en pulses, in the pattern 4 on, 2 off, 4 on; frame_done exactly DRAIN_CYC+1 cycles after the last codec_en_out; pix_cnt=8.
- start with cfg_width=1 -> err_cfg 1-cycle pulse, busy stays 0.
- out_afull=1 for 5 cycles mid-row -> src_ready=0 and no codec_en for those 5 cycles (allowing the 1-cycle latency); col resumes without loss or duplication of data.
- abort at pixel 3 of row 1 -> IDLE next edge, codec_en=0, no frame_done; a new start restarts with pix_cnt=0.
- codec_en_out pulsed every 10 cycles during DRAIN with DRAIN_CYC=16 -> no frame_done until 16 quiet cycles have passed.
- reset pulled low during FEED -> all outputs 0 asynchronously; no frame_done after release.
